// File: rtl/uart_rx_frame_if.sv
// Serial-line bundle for uart_rx_frame: line input plus decoded character and status.
// master = line driver / consumer side, slave = the receiver.
interface uart_rx_frame_if;
  logic       s_in;
  logic       received;
  logic [6:0] received_data;
  logic       check;
  logic       frame_err;
  logic       busy;

  modport master (
    output s_in,
    input  received, received_data, check, frame_err, busy
  );

  modport slave (
    input  s_in,
    output received, received_data, check, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling receiver for a 7-bit + even-parity UART frame (start, d0..d6, parity, stop).
// Define UART_RX_SYNC_EN to pass s_in through a 2-flop synchronizer (all timing +2 cycles).
module uart_rx_frame #(
  parameter logic        START_SIG    = 1'b1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic            clk,
  input logic            rst,
  uart_rx_frame_if.slave bus
);

  localparam int unsigned     CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            received_q, received_d;
  logic [6:0]      data_q, data_d;
  logic            check_q, check_d;
  logic            ferr_q, ferr_d;
  logic            s;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= ~START_SIG;
      sync2_q <= ~START_SIG;
    end else begin
      sync1_q <= bus.s_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = bus.s_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      received_q <= 1'b0;
      data_q     <= '0;
      check_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      received_q <= received_d;
      data_q     <= data_d;
      check_q    <= check_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    received_d = 1'b0;
    data_d     = data_q;
    check_d    = check_q;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (s == START_SIG) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Mid-bit re-check filters glitches shorter than half a bit
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (s == START_SIG) ? S_DATA : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {s, shift_q[6:1]};
          if (bit_q == 3'd6) begin
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (s != START_SIG) begin
            received_d = 1'b1;
            data_d     = shift_q;
            check_d    = ((^shift_q) == par_q);
            state_d    = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (s != START_SIG) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.received      = received_q;
  assign bus.received_data = data_q;
  assign bus.check         = check_q;
  assign bus.frame_err     = ferr_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame (START_SIG=1, 16 clocks per bit).
// Table of single frames plus hand-written glitch, break, back-to-back and reset sequences.
module tb_uart_rx_frame;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT = H + 9 * C + 1 + SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  uart_rx_frame_if bus ();

  uart_rx_frame #(
    .START_SIG    (1'b1),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] data;
    logic       chk;
  } rx_t;

  rx_t rx_q[$];
  int  fe_q[$];
  int  busy_cnt = 0;

  always @(negedge clk) begin
    if (bus.received)  rx_q.push_back('{cyc, bus.received_data, bus.check});
    if (bus.frame_err) fe_q.push_back(cyc);
    if (bus.busy)      busy_cnt++;
  end

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       exp_chk;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.s_in = b;
    step(C);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b1);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.s_in = 1'b0;
    step(n);
  endtask

  task automatic clear_log();
    rx_q.delete();
    fe_q.delete();
  endtask

  function automatic int rx_cyc(input int i);
    return (rx_q.size() > i) ? rx_q[i].cyc : -1;
  endfunction

  function automatic int rx_dat(input int i);
    return (rx_q.size() > i) ? int'(rx_q[i].data) : -1;
  endfunction

  function automatic int rx_chk(input int i);
    return (rx_q.size() > i) ? int'(rx_q[i].chk) : -1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1;

    vecs[0] = '{7'h45, 1'b1, 1'b1};
    vecs[1] = '{7'h61, 1'b0, 1'b0};
    vecs[2] = '{7'h6C, 1'b0, 1'b1};
    vecs[3] = '{7'h7F, 1'b0, 1'b0};
    vecs[4] = '{7'h00, 1'b0, 1'b1};
    vecs[5] = '{7'h2A, 1'b1, 1'b1};

    bus.s_in = 1'b0;
    rst      = 1'b1;
    step(3);
    check("reset_received", int'(bus.received), 0);
    check("reset_data", int'(bus.received_data), 0);
    check("reset_check", int'(bus.check), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    check("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;
    idle(4);

    for (int v = 0; v < 6; v++) begin
      clear_log();
      send_frame(vecs[v].data, vecs[v].par, 1'b0, t0);
      idle(4);
      check($sformatf("vec%0d_count", v), rx_q.size(), 1);
      check($sformatf("vec%0d_latency", v), rx_cyc(0) - t0, LAT);
      check($sformatf("vec%0d_data", v), rx_dat(0), int'(vecs[v].data));
      check($sformatf("vec%0d_check", v), rx_chk(0), int'(vecs[v].exp_chk));
      check($sformatf("vec%0d_held", v), int'(bus.received_data), int'(vecs[v].data));
      check($sformatf("vec%0d_no_ferr", v), fe_q.size(), 0);
    end

    // Short glitch: START entered then abandoned at the half-bit re-check
    clear_log();
    busy_cnt = 0;
    bus.s_in = 1'b1;
    step(3);
    idle(24);
    check("glitch_busy_cycles", busy_cnt, H);
    check("glitch_no_rx", rx_q.size(), 0);
    check("glitch_no_ferr", fe_q.size(), 0);

    // Bad stop bit followed by a held line, then a good frame
    clear_log();
    send_frame(7'h67, 1'b1, 1'b1, t0);
    bus.s_in = 1'b1;
    step(40);
    check("break_busy_held", int'(bus.busy), 1);
    idle(8);
    check("break_busy_released", int'(bus.busy), 0);
    check("break_ferr_count", fe_q.size(), 1);
    check("break_ferr_latency", (fe_q.size() > 0) ? fe_q[0] - t0 : -1, LAT);
    check("break_no_rx", rx_q.size(), 0);
    check("break_data_kept", int'(bus.received_data), 7'h2A);
    check("break_check_kept", int'(bus.check), 1);
    clear_log();
    send_frame(7'h6C, 1'b0, 1'b0, t0);
    idle(4);
    check("after_break_count", rx_q.size(), 1);
    check("after_break_data", rx_dat(0), 7'h6C);
    check("after_break_check", rx_chk(0), 1);

    // Back-to-back frames, no idle gap
    clear_log();
    send_frame(7'h6C, 1'b0, 1'b0, t0);
    send_frame(7'h65, 1'b0, 1'b0, t1);
    idle(4);
    check("b2b_count", rx_q.size(), 2);
    check("b2b_latency", rx_cyc(0) - t0, LAT);
    check("b2b_spacing", rx_cyc(1) - rx_cyc(0), 10 * C);
    check("b2b_data0", rx_dat(0), 7'h6C);
    check("b2b_data1", rx_dat(1), 7'h65);
    check("b2b_check1", rx_chk(1), 1);
    check("b2b_no_ferr", fe_q.size(), 0);

    // Reset in the middle of data bit 3 of 'W'; the sender abandons the frame too
    clear_log();
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    bus.s_in = 1'b0;
    step(8);
    check("midrst_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    step(1);
    check("midrst_received", int'(bus.received), 0);
    check("midrst_data", int'(bus.received_data), 0);
    check("midrst_check", int'(bus.check), 0);
    check("midrst_frame_err", int'(bus.frame_err), 0);
    check("midrst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    idle(3 * C);
    check("midrst_no_rx", rx_q.size(), 0);
    check("midrst_no_ferr", fe_q.size(), 0);
    clear_log();
    send_frame(7'h6F, 1'b0, 1'b0, t0);
    idle(4);
    check("after_rst_count", rx_q.size(), 1);
    check("after_rst_latency", rx_cyc(0) - t0, LAT);
    check("after_rst_data", rx_dat(0), 7'h6F);
    check("after_rst_check", rx_chk(0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
